// File: rtl/ad5628_seq_ctrl.sv
// AD5628 power-up/configuration sequencer: issues reset, reference-on and eight
// channel writes over an external SPI master, then scans the DG636 mux.
module ad5628_seq_ctrl #(
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 2048,
  parameter int DWELL_CYC   = 50
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        start,
  output logic [2:0]  code_sel,
  input  logic [11:0] code_in,
  output logic        spi_start,
  output logic [31:0] spi_data,
  input  logic        spi_busy,
  input  logic        spi_done,
  output logic        A0,
  output logic        A1,
  output logic        wave_en,
  output logic        busy,
  output logic        cfg_done,
  output logic        err
);

  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int TMO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int DWELL_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;

  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYC - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYC - 1);
  localparam logic [3:0]         LAST_FRAME = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_SCAN,
    S_ERR
  } state_e;

  state_e               state_q;
  logic [3:0]           frame_q;
  logic [2:0]           code_sel_q;
  logic                 spi_start_q;
  logic [31:0]          spi_data_q;
  logic [1:0]           chan_q;
  logic                 wave_en_q;
  logic                 busy_q;
  logic                 cfg_done_q;
  logic                 err_q;
  logic [GAP_W-1:0]     gap_cnt_q;
  logic [TMO_W-1:0]     tmo_cnt_q;
  logic [DWELL_W-1:0]   dwell_cnt_q;

  logic                 restart_d;
  logic [3:0]           frame_dec_d;
  logic [2:0]           code_sel_d;

  // Frame f0 is a software reset, f1 turns the internal reference on, f2..f9
  // write-and-update DAC channels 0..7 with the externally supplied code.
  function automatic logic [31:0] frame_word(input logic [3:0] f, input logic [11:0] code);
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [11:0] data;
    if (f == 4'd0) begin
      cmd  = 4'h7;
      addr = 4'h0;
      data = 12'h000;
    end else if (f == 4'd1) begin
      cmd  = 4'h8;
      addr = 4'h0;
      data = 12'h001;
    end else begin
      cmd  = 4'h3;
      addr = f - 4'd2;
      data = code;
    end
    return {4'h0, cmd, addr, data, 8'h00};
  endfunction

  assign restart_d   = start && ((state_q == S_IDLE) || (state_q == S_SCAN) || (state_q == S_ERR));
  assign frame_dec_d = frame_q - 4'd1;
  // code_sel for the frame that follows frame_q, i.e. channel (frame_q + 1) - 2
  assign code_sel_d  = (frame_q == 4'd0) ? 3'd0 : frame_dec_d[2:0];

  // Counters are only non-zero inside their own state and are zeroed on every
  // exit, so each state is always entered with its counter at zero.
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      state_q     <= S_IDLE;
      frame_q     <= 4'd0;
      code_sel_q  <= 3'd0;
      spi_start_q <= 1'b0;
      spi_data_q  <= 32'd0;
      chan_q      <= 2'd0;
      wave_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      cfg_done_q  <= 1'b0;
      err_q       <= 1'b0;
      gap_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      dwell_cnt_q <= '0;
    end else begin
      spi_start_q <= 1'b0;
      if (restart_d) begin
        state_q     <= S_ISSUE;
        frame_q     <= 4'd0;
        code_sel_q  <= 3'd0;
        chan_q      <= 2'd0;
        wave_en_q   <= 1'b0;
        busy_q      <= 1'b1;
        cfg_done_q  <= 1'b0;
        err_q       <= 1'b0;
        gap_cnt_q   <= '0;
        tmo_cnt_q   <= '0;
        dwell_cnt_q <= '0;
      end else begin
        unique case (state_q)
          S_ISSUE: begin
            if (!spi_busy) begin
              spi_data_q  <= frame_word(frame_q, code_in);
              spi_start_q <= 1'b1;
              tmo_cnt_q   <= '0;
              state_q     <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (spi_done) begin
              tmo_cnt_q <= '0;
              gap_cnt_q <= '0;
              state_q   <= S_GAP;
            end else if (tmo_cnt_q == TMO_LAST) begin
              tmo_cnt_q <= '0;
              err_q     <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= S_ERR;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
          end
          S_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
              gap_cnt_q <= '0;
              if (frame_q == LAST_FRAME) begin
                cfg_done_q  <= 1'b1;
                busy_q      <= 1'b0;
                wave_en_q   <= 1'b1;
                chan_q      <= 2'd0;
                dwell_cnt_q <= '0;
                state_q     <= S_SCAN;
              end else begin
                frame_q    <= frame_q + 4'd1;
                code_sel_q <= code_sel_d;
                state_q    <= S_ISSUE;
              end
            end else begin
              gap_cnt_q <= gap_cnt_q + GAP_W'(1);
            end
          end
          S_SCAN: begin
            if (dwell_cnt_q == DWELL_LAST) begin
              dwell_cnt_q <= '0;
              chan_q      <= chan_q + 2'd1;
            end else begin
              dwell_cnt_q <= dwell_cnt_q + DWELL_W'(1);
            end
          end
          default: begin
            state_q <= state_q;
          end
        endcase
      end
    end
  end

  assign code_sel  = code_sel_q;
  assign spi_start = spi_start_q;
  assign spi_data  = spi_data_q;
  assign A0        = chan_q[0];
  assign A1        = chan_q[1];
  assign wave_en   = wave_en_q;
  assign busy      = busy_q;
  assign cfg_done  = cfg_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ad5628_seq_ctrl.sv
// Directed bench for ad5628_seq_ctrl: frame table, scan timing, busy hold-off,
// timeout, reconfiguration and mid-frame reset against a stub SPI master.
module tb_ad5628_seq_ctrl;

  localparam int GAP_CYC     = 4;
  localparam int TIMEOUT_CYC = 2048;
  localparam int DWELL_CYC   = 50;
  localparam int STUB_LAT    = 40;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic        start;
  logic [2:0]  code_sel;
  logic [11:0] code_in;
  logic        spi_start;
  logic [31:0] spi_data;
  logic        spi_busy;
  logic        spi_done;
  logic        A0, A1, wave_en, busy, cfg_done, err;

  logic [11:0] codes [8];
  logic        stub_busy = 1'b0;
  logic        stub_done = 1'b0;
  logic        hold_busy = 1'b0;
  logic        inj_done  = 1'b0;

  assign code_in  = codes[code_sel];
  assign spi_busy = stub_busy | hold_busy;
  assign spi_done = stub_done | inj_done;

  ad5628_seq_ctrl #(
    .GAP_CYC    (GAP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .DWELL_CYC  (DWELL_CYC)
  ) dut (
    .clk_sys  (clk_sys),
    .rst_sys  (rst_sys),
    .start    (start),
    .code_sel (code_sel),
    .code_in  (code_in),
    .spi_start(spi_start),
    .spi_data (spi_data),
    .spi_busy (spi_busy),
    .spi_done (spi_done),
    .A0       (A0),
    .A1       (A1),
    .wave_en  (wave_en),
    .busy     (busy),
    .cfg_done (cfg_done),
    .err      (err)
  );

  always #5 clk_sys = ~clk_sys;

  // Stub SPI master, evaluated on the falling edge
  int          cyc = 0;
  int          stub_cnt = 0;
  bit          stub_act = 1'b0;
  int          stub_fr = 0;
  int          drop_fr = -1;
  int          last_done = 0;
  logic [31:0] cap_data [$];
  int          cap_cyc [$];
  int          cap_gap [$];

  always @(negedge clk_sys) begin
    cyc = cyc + 1;
    stub_done = 1'b0;
    if (start) stub_fr = 0;
    if (stub_act) begin
      stub_cnt = stub_cnt + 1;
      if (stub_cnt >= STUB_LAT) begin
        stub_act  = 1'b0;
        stub_busy = 1'b0;
        stub_done = 1'b1;
        last_done = cyc;
      end
    end
    if (spi_start) begin
      cap_data.push_back(spi_data);
      cap_cyc.push_back(cyc);
      cap_gap.push_back(cyc - last_done);
      if (stub_fr != drop_fr) begin
        stub_act  = 1'b1;
        stub_cnt  = 0;
        stub_busy = 1'b1;
      end
      stub_fr = stub_fr + 1;
    end
  end

  typedef struct {
    logic [11:0] code;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_cfg(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (cfg_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  function automatic logic [31:0] ctl_word();
    return {22'd0, spi_start, code_sel, A1, A0, wave_en, busy, cfg_done, err};
  endfunction

  initial begin
    bit ok;
    int base;
    int nst;
    int ecyc;

    vecs[0] = '{12'h000, 32'h07000000};
    vecs[1] = '{12'h000, 32'h08000100};
    vecs[2] = '{12'h123, 32'h03012300};
    vecs[3] = '{12'h456, 32'h03145600};
    vecs[4] = '{12'h789, 32'h03278900};
    vecs[5] = '{12'hABC, 32'h033ABC00};
    vecs[6] = '{12'hFFF, 32'h034FFF00};
    vecs[7] = '{12'h000, 32'h03500000};
    vecs[8] = '{12'h800, 32'h03680000};
    vecs[9] = '{12'h001, 32'h03700100};
    for (int i = 0; i < 8; i++) codes[i] = vecs[i + 2].code;

    rst_sys = 1'b0;
    start   = 1'b0;
    repeat (3) tick();
    check("rst_ctl", ctl_word(), 32'd0);
    check("rst_data", spi_data, 32'd0);
    rst_sys = 1'b1;
    repeat (5) tick();
    check("idle_no_frame", 32'(cap_data.size()), 32'd0);
    check("idle_ctl", ctl_word(), 32'd0);

    // Nominal configuration; the second start lands mid-sequence and must be ignored
    base = cap_data.size();
    pulse_start();
    check("start_busy", {30'd0, busy, cfg_done}, 32'b10);
    repeat (60) tick();
    pulse_start();
    wait_cfg(ok);
    check("cfg_wait", 32'(ok), 32'd1);
    check("frame_count", 32'(cap_data.size() - base), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("frame%0d", i), cap_data[base + i], vecs[i].exp);
      if (i > 0) check($sformatf("gap%0d", i), 32'(cap_gap[base + i]), 32'(GAP_CYC + 2));
    end
    check("cfg_status", {28'd0, cfg_done, wave_en, busy, err}, 32'b1100);

    // Scan: first observation is the cycle right after SCAN entry
    for (int n = 0; n <= 4 * DWELL_CYC; n++) begin
      if ((n % DWELL_CYC == 0) || (n % DWELL_CYC == DWELL_CYC - 1))
        check($sformatf("scan_n%0d", n), {30'd0, A1, A0}, 32'((n / DWELL_CYC) % 4));
      tick();
    end
    check("scan_wave", 32'(wave_en), 32'd1);

    // Reconfiguration from SCAN with a new channel-0 code
    codes[0] = 12'hABC;
    base = cap_data.size();
    pulse_start();
    check("recfg_exit", {27'd0, wave_en, A1, A0, busy, cfg_done}, 32'b00010);
    wait_cfg(ok);
    check("recfg_wait", 32'(ok), 32'd1);
    check("recfg_f0", cap_data[base], 32'h07000000);
    check("recfg_ch0", cap_data[base + 2], 32'h030ABC00);

    // Busy hold-off on entry to ISSUE, then frame 1 is never answered
    base = cap_data.size();
    hold_busy = 1'b1;
    drop_fr = 1;
    pulse_start();
    nst = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (spi_start) nst++;
    end
    check("holdoff_quiet", 32'(nst + cap_data.size() - base), 32'd0);
    hold_busy = 1'b0;
    tick();
    check("holdoff_launch", 32'(spi_start), 32'd1);

    ok = 1'b0;
    ecyc = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (err) begin
        ok = 1'b1;
        ecyc = cyc;
        break;
      end
    end
    check("timeout_seen", 32'(ok), 32'd1);
    check("timeout_len", 32'(ecyc - cap_cyc[base + 1]), 32'(TIMEOUT_CYC));
    check("err_state", {26'd0, err, busy, wave_en, A1, A0, cfg_done}, 32'b100000);

    // A stray spi_done in ERR changes nothing
    base = cap_data.size();
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    repeat (3) tick();
    check("err_sticky", {30'd0, err, busy}, 32'b10);
    check("err_no_frame", 32'(cap_data.size() - base), 32'd0);

    // Restart from ERR, then reset during the f5 wait
    drop_fr = -1;
    base = cap_data.size();
    pulse_start();
    check("restart_clr", {30'd0, err, busy}, 32'b01);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (cap_data.size() - base >= 6) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("reach_f5", 32'(ok), 32'd1);
    check("restart_f0", cap_data[base], 32'h07000000);
    repeat (10) tick();
    check("f5_wait", {28'd0, busy, code_sel}, 32'b1011);
    rst_sys = 1'b0;
    #1;
    check("midrst_ctl", ctl_word(), 32'd0);
    check("midrst_data", spi_data, 32'd0);
    repeat (3) tick();
    rst_sys = 1'b1;
    base = cap_data.size();
    repeat (150) tick();
    check("postrst_quiet", 32'(cap_data.size() - base), 32'd0);
    check("postrst_ctl", ctl_word(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
